// File: rtl/datapath_ctrl_fsm.sv
// rtl/datapath_ctrl_fsm.sv - multi-cycle control sequencer for the register/ALU/data-memory datapath
//
// Accepts one instruction at a time, latches it, and walks the datapath through
// READ -> EXEC -> (MEM) -> (WB), driving the datapath controls from the state and
// the latched instruction.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instr_valid/instr   offered instruction word
//   instr_ready         controller idle and able to accept an instruction
//   zero                ALU zero flag, sampled for beq in EXEC
//   Instruction         latched instr[25:0] field bus
//   RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, ALUControl_Signal
//                       datapath controls (0 in IDLE)
//   done                final cycle of an instruction
//   branch_taken        beq outcome, valid with done
//   illegal             one-cycle pulse after an undecodable instruction is accepted
module datapath_ctrl_fsm #(
  parameter int READ_LAT       = 1,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        zero,
  output logic [25:0] Instruction,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic [3:0]  ALUControl_Signal,
  output logic        done,
  output logic        branch_taken,
  output logic        illegal
);

  localparam logic [3:0] ALU_COMPLEMENT = 4'b0000;
  localparam logic [3:0] ALU_AND        = 4'b0001;
  localparam logic [3:0] ALU_XOR        = 4'b0010;
  localparam logic [3:0] ALU_OR         = 4'b0011;
  localparam logic [3:0] ALU_DEC        = 4'b0100;
  localparam logic [3:0] ALU_ADD        = 4'b0101;
  localparam logic [3:0] ALU_SUB        = 4'b0110;
  localparam logic [3:0] ALU_INC        = 4'b0111;

  // READ wait counter counts down from READ_LAT-1 to 0.
  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_e;
  typedef enum logic [2:0] {C_R, C_IMM, C_LW, C_SW, C_BEQ} cls_e;

  typedef struct packed {
    logic       legal;
    cls_e       cls;
    logic [3:0] alu;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = C_R;
    d.alu   = ALU_ADD;
    case (w[31:26])
      6'b000000: begin
        case (w[5:0])
          6'b100000: d.alu = ALU_ADD;
          6'b100010: d.alu = ALU_SUB;
          6'b100100: d.alu = ALU_AND;
          6'b100101: d.alu = ALU_OR;
          6'b100110: d.alu = ALU_XOR;
          6'b110000: d.alu = ALU_COMPLEMENT;
          6'b110001: d.alu = ALU_DEC;
          6'b110010: d.alu = ALU_INC;
          default:   d.legal = 1'b0;
        endcase
      end
      6'b001000: begin d.cls = C_IMM; d.alu = ALU_ADD; end
      6'b001100: begin d.cls = C_IMM; d.alu = ALU_AND; end
      6'b001101: begin d.cls = C_IMM; d.alu = ALU_OR;  end
      6'b001110: begin d.cls = C_IMM; d.alu = ALU_XOR; end
      6'b100011: begin d.cls = C_LW;  d.alu = ALU_ADD; end
      6'b101011: begin d.cls = C_SW;  d.alu = ALU_ADD; end
      6'b000100: begin d.cls = C_BEQ; d.alu = ALU_SUB; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_e      state_q;
  logic [31:0] instr_q;
  logic [1:0]  cnt_q;
  logic        illegal_q;

  dec_t dec_in;
  dec_t dec_q;
  assign dec_in = decode(instr);
  assign dec_q  = decode(instr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            if (dec_in.legal) begin
              state_q <= S_READ;
              cnt_q   <= CNT_INIT;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (cnt_q == 2'd0) state_q <= S_EXEC;
          else               cnt_q   <= cnt_q - 2'd1;
        end
        S_EXEC: begin
          case (dec_q.cls)
            C_LW, C_SW: state_q <= S_MEM;
            C_BEQ:      state_q <= S_IDLE;
            default:    state_q <= S_WB;
          endcase
        end
        S_MEM:   state_q <= (dec_q.cls == C_LW) ? S_WB : S_IDLE;
        S_WB:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [4:0] dest;
  logic       alu_phase;
  assign dest      = (dec_q.cls == C_R) ? instr_q[15:11] : instr_q[20:16];
  // ALU controls are set up in EXEC and held through MEM and WB.
  assign alu_phase = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    RegDst            = 1'b0;
    ALUSrc            = 1'b0;
    MemRead           = 1'b0;
    MemWrite          = 1'b0;
    MemToReg          = 1'b0;
    RegWrite          = 1'b0;
    ALUControl_Signal = 4'b0000;
    done              = 1'b0;
    branch_taken      = 1'b0;
    if (alu_phase) begin
      ALUControl_Signal = dec_q.alu;
      ALUSrc            = (dec_q.cls == C_IMM) || (dec_q.cls == C_LW) || (dec_q.cls == C_SW);
    end
    case (state_q)
      S_EXEC: begin
        if (dec_q.cls == C_BEQ) begin
          done         = 1'b1;
          branch_taken = zero;
        end
      end
      S_MEM: begin
        if (dec_q.cls == C_LW) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
          done     = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = !(ZERO_REG_GUARD && (dest == 5'd0));
        RegDst   = (dec_q.cls == C_R);
        MemToReg = (dec_q.cls == C_LW);
        MemRead  = (dec_q.cls == C_LW);
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Ready is gated by rst_n so it reads 0 while reset is held.
  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign Instruction = instr_q[25:0];
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// tb/tb_datapath_ctrl_fsm.sv - directed self-checking bench for datapath_ctrl_fsm
module tb_datapath_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid1 = 1'b0;
  logic        valid3 = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;

  logic        rdy1, rdy3;
  logic [25:0] ins1, ins3;
  logic        rd1, as1, mr1, mw1, mtr1, rw1, dn1, bt1, il1;
  logic        rd3, as3, mr3, mw3, mtr3, rw3, dn3, bt3, il3;
  logic [3:0]  alu1, alu3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath_ctrl_fsm #(.READ_LAT(1), .ZERO_REG_GUARD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid1), .instr(instr), .instr_ready(rdy1),
    .zero(zero), .Instruction(ins1), .RegDst(rd1), .ALUSrc(as1), .MemRead(mr1),
    .MemWrite(mw1), .MemToReg(mtr1), .RegWrite(rw1), .ALUControl_Signal(alu1),
    .done(dn1), .branch_taken(bt1), .illegal(il1)
  );

  datapath_ctrl_fsm #(.READ_LAT(3), .ZERO_REG_GUARD(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid3), .instr(instr), .instr_ready(rdy3),
    .zero(zero), .Instruction(ins3), .RegDst(rd3), .ALUSrc(as3), .MemRead(mr3),
    .MemWrite(mw3), .MemToReg(mtr3), .RegWrite(rw3), .ALUControl_Signal(alu3),
    .done(dn3), .branch_taken(bt3), .illegal(il3)
  );

  // {RegDst,ALUSrc,MemRead,MemWrite,MemToReg,RegWrite}_{ALU}_{done,branch_taken,illegal,instr_ready}
  logic [13:0] ctl1, ctl3;
  assign ctl1 = {rd1, as1, mr1, mw1, mtr1, rw1, alu1, dn1, bt1, il1, rdy1};
  assign ctl3 = {rd3, as3, mr3, mw3, mtr3, rw3, alu3, dn3, bt3, il3, rdy3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tv_instr [9];
  logic [3:0]  tv_alu   [9];
  logic        tv_src   [9];

  initial begin
    tv_instr[0] = 32'h00221822; tv_alu[0] = 4'b0110; tv_src[0] = 1'b0;
    tv_instr[1] = 32'h00221824; tv_alu[1] = 4'b0001; tv_src[1] = 1'b0;
    tv_instr[2] = 32'h00221825; tv_alu[2] = 4'b0011; tv_src[2] = 1'b0;
    tv_instr[3] = 32'h00221826; tv_alu[3] = 4'b0010; tv_src[3] = 1'b0;
    tv_instr[4] = 32'h00221830; tv_alu[4] = 4'b0000; tv_src[4] = 1'b0;
    tv_instr[5] = 32'h00221831; tv_alu[5] = 4'b0100; tv_src[5] = 1'b0;
    tv_instr[6] = 32'h00221832; tv_alu[6] = 4'b0111; tv_src[6] = 1'b0;
    tv_instr[7] = 32'h30230005; tv_alu[7] = 4'b0001; tv_src[7] = 1'b1;
    tv_instr[8] = 32'h38230005; tv_alu[8] = 4'b0010; tv_src[8] = 1'b1;

    // Reset held
    #2;
    check("reset_ctl", 32'(ctl1), 32'h0);
    check("reset_ctl3", 32'(ctl3), 32'h0);
    check("reset_instr", 32'(ins1), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("release_ready", 32'(ctl1), 32'(14'b000000_0000_0001));

    // add $3,$1,$2 with valid held and instr changed while busy
    tick();
    instr = 32'h00221820; valid1 = 1'b1;
    tick();
    instr = 32'hAC450004;
    check("add_read", 32'(ctl1), 32'(14'b000000_0000_0000));
    check("add_field", 32'(ins1), 32'h0221820);
    tick();
    check("add_exec", 32'(ctl1), 32'(14'b000000_0101_0000));
    check("add_field_held", 32'(ins1), 32'h0221820);
    tick();
    valid1 = 1'b0;
    check("add_wb", 32'(ctl1), 32'(14'b100001_0101_1000));
    tick();
    check("add_idle", 32'(ctl1), 32'(14'b000000_0000_0001));

    // lw $5,8($1)
    instr = 32'h8C250008; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    check("lw_read", 32'(ctl1), 32'(14'b000000_0000_0000));
    tick();
    check("lw_exec", 32'(ctl1), 32'(14'b010000_0101_0000));
    tick();
    check("lw_mem", 32'(ctl1), 32'(14'b011000_0101_0000));
    tick();
    check("lw_wb", 32'(ctl1), 32'(14'b011011_0101_1000));
    tick();
    check("lw_idle", 32'(ctl1), 32'(14'b000000_0000_0001));

    // sw $5,4($2)
    instr = 32'hAC450004; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    check("sw_read", 32'(ctl1), 32'(14'b000000_0000_0000));
    tick();
    check("sw_exec", 32'(ctl1), 32'(14'b010000_0101_0000));
    tick();
    check("sw_mem", 32'(ctl1), 32'(14'b010100_0101_1000));
    tick();
    check("sw_idle", 32'(ctl1), 32'(14'b000000_0000_0001));

    // beq taken then not taken
    instr = 32'h10220003; valid1 = 1'b1; zero = 1'b1;
    tick(); valid1 = 1'b0;
    check("beq_read", 32'(ctl1), 32'(14'b000000_0000_0000));
    tick();
    check("beq_taken", 32'(ctl1), 32'(14'b000000_0110_1100));
    tick();
    check("beq_idle", 32'(ctl1), 32'(14'b000000_0000_0001));
    valid1 = 1'b1; zero = 1'b0;
    tick(); valid1 = 1'b0;
    tick();
    check("beq_not_taken", 32'(ctl1), 32'(14'b000000_0110_1000));
    tick();

    // Illegal opcode and illegal funct
    instr = 32'hFC000000; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    check("ill_op_pulse", 32'(ctl1), 32'(14'b000000_0000_0011));
    tick();
    check("ill_op_after", 32'(ctl1), 32'(14'b000000_0000_0001));
    instr = 32'h0000003F; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    check("ill_fn_pulse", 32'(ctl1), 32'(14'b000000_0000_0011));
    tick();
    check("ill_fn_after", 32'(ctl1), 32'(14'b000000_0000_0001));

    // addi $0,$1,5: register write suppressed
    instr = 32'h20200005; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    tick();
    check("addi0_exec", 32'(ctl1), 32'(14'b010000_0101_0000));
    tick();
    check("addi0_wb", 32'(ctl1), 32'(14'b010000_0101_1000));
    tick();

    // Remaining R-type and immediate ALU codes
    for (int i = 0; i < 9; i++) begin
      instr = tv_instr[i]; valid1 = 1'b1;
      tick(); valid1 = 1'b0;
      tick();
      check($sformatf("alu_exec_%0d", i), 32'(ctl1),
            32'({1'b0, tv_src[i], 4'b0000, tv_alu[i], 4'b0000}));
      tick();
      check($sformatf("alu_wb_%0d", i), 32'(ctl1),
            32'({~tv_src[i], tv_src[i], 3'b000, 1'b1, tv_alu[i], 4'b1000}));
      tick();
    end

    // READ_LAT=3: addi $3,$1,5 completes 5 cycles after accept
    instr = 32'h20230005; valid3 = 1'b1;
    tick(); valid3 = 1'b0;
    check("rl3_c1", 32'(ctl3), 32'(14'b000000_0000_0000));
    tick();
    check("rl3_c2", 32'(ctl3), 32'(14'b000000_0000_0000));
    tick();
    check("rl3_c3", 32'(ctl3), 32'(14'b000000_0000_0000));
    tick();
    check("rl3_exec", 32'(ctl3), 32'(14'b010000_0101_0000));
    tick();
    check("rl3_wb", 32'(ctl3), 32'(14'b010001_0101_1000));
    tick();
    check("rl3_idle", 32'(ctl3), 32'(14'b000000_0000_0001));

    // Reset mid-EXEC aborts the add
    instr = 32'h00221820; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    tick();
    check("rst_pre_exec", 32'(ctl1), 32'(14'b000000_0101_0000));
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 32'(ctl1), 32'h0);
    check("rst_mid_instr", 32'(ins1), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 32'(ctl1), 32'(14'b000000_0000_0001));
    tick();
    check("rst_no_done", 32'(ctl1), 32'(14'b000000_0000_0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl_fsm.md
Name: datapath_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the single-issue register/ALU/data-memory datapath.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and latches it.
- Decodes opcode/funct and steps the datapath through READ, EXEC, MEM and WB phases by driving its control inputs and the 26-bit instruction field bus.
- Accounts for the registered (one-edge) register-file read latency and reports completion, branch outcome and illegal encodings.

Parameters:
- READ_LAT, 1: number of READ wait cycles before EXEC (legal range 1..3); covers the registered register-file read.
- ZERO_REG_GUARD, 1: when 1, RegWrite is suppressed if the destination register is 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  instruction word.
- instr_ready  out  1  controller can accept an instruction.
- zero  in  1  ALU zero flag from the datapath.
- Instruction  out  26  latched instr[25:0], held stable from accept until return to IDLE.
- RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite  out  1 each  datapath controls.
- ALUControl_Signal  out  4  ALU op code.
- done  out  1  high for exactly one cycle: the final cycle of an instruction.
- branch_taken  out  1  valid when done=1 for beq.
- illegal  out  1  one-cycle pulse when an undecodable instruction is accepted.

Behaviour:
- Reset: asynchronous, active low.
  - While rst_n=0: state=IDLE, latched instr=0, every output 0, including instr_ready.
  - On rst_n release, instr_ready=1 from the first cycle.
  - Reset asserted mid-instruction aborts it immediately; the instruction produces no write and no done.
- ALU codes:
  - COMPLEMENT 0000, AND 0001, XOR 0010, OR 0011, DEC 0100, ADD 0101, SUB 0110, INC 0111.
- Decode, opcode instr[31:26]:
  - 000000 R-type, by funct instr[5:0]:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR.
    - 110000 COMPLEMENT, 110001 DEC, 110010 INC.
    - Any other funct is illegal.
  - Immediate ops: 001000 addi=ADD, 001100 andi=AND, 001101 ori=OR, 001110 xori=XOR.
  - Memory ops: 100011 lw (ADD), 101011 sw (ADD).
  - 000100 beq (SUB).
  - Every other opcode is illegal.
- States:
  - IDLE:
    - instr_ready=1.
    - On instr_valid&instr_ready, latch instr.
    - If legal, go to READ; if illegal, pulse illegal on the next cycle and stay in IDLE.
  - READ:
    - All strobes (MemRead, MemWrite, RegWrite) are 0; Instruction is driven.
    - Stay READ_LAT cycles (down-counter), then go to EXEC.
  - EXEC:
    - ALUControl_Signal and ALUSrc are driven: ALUSrc=1 for immediate ops and lw/sw, 0 otherwise.
    - ALU ops, addi/andi/ori/xori → WB.
    - lw, sw → MEM.
    - beq: branch_taken=zero, done=1 → IDLE.
  - MEM:
    - ALUSrc and ALUControl_Signal are held.
    - lw: MemRead=1 → WB.
    - sw: MemWrite=1, done=1 → IDLE.
  - WB:
    - RegWrite=1 (0 if ZERO_REG_GUARD and destination=0).
    - Destination is instr[15:11] for R-type, instr[20:16] otherwise.
    - RegDst=1 only for R-type; MemToReg=1 and MemRead=1 only for lw; ALU controls held.
    - done=1 → IDLE.
- Control-output timing: all controls are combinational from state and the latched instruction, and are 0 in IDLE.
- Latency from accept edge to done cycle, with READ_LAT=1:
  - R-type / immediate: 3 cycles.
  - lw: 4 cycles.
  - sw: 3 cycles.
  - beq: 2 cycles.
- Back-to-back: a new instruction is accepted no earlier than the cycle after done; no overlap.
- Boundary cases:
  - instr_valid held during a busy phase is ignored.
  - instr changing while busy has no effect.
  - The latched instr is never updated outside IDLE.

Test Plan:
1. Reset: rst_n=0 mid-EXEC of 0x00221820 → all outputs 0 immediately. After release: instr_ready=1, no done, no RegWrite.
2. add $3,$1,$2 (0x00221820) → READ 1 cycle; then EXEC with ALUControl=0101, ALUSrc=0; then WB with RegWrite=1, RegDst=1, done=1. Total 3 cycles.
3. lw $5,8($1) (0x8C250008) → EXEC ALUSrc=1, ALU=0101; MEM MemRead=1; WB RegWrite=1, MemToReg=1, RegDst=0. done at cycle 4.
4. sw $5,4($2) (0xAC450004) → MEM MemWrite=1, done=1, RegWrite never 1. beq 0x10220003 with zero=1 → ALU=0110, done and branch_taken=1 at cycle 2.
5. Illegal 0xFC000000 and R-type funct 0x3F → illegal=1 for one cycle, no strobes, instr_ready back to 1.
6. addi $0,$1,5 (0x20200005), ZERO_REG_GUARD=1 → WB with RegWrite=0, done=1. With READ_LAT=3, latency is 5 cycles.
